// File: rtl/sysbus_decoder.sv
// sysbus_decoder
// Region-matched address decoder and read-data return mux for the RISC_V
// system bus. Routes each access to one of N_SLAVES slave ports by comparing
// the address field m_addr[SEL_HI:SEL_LO] against a per-slave region code.
// Read data comes back exactly one cycle after the request. Unmapped accesses
// are logged in sticky error status registers.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   m_en, m_rdwr    master request strobe and direction (1=write, 0=read)
//   m_addr          master byte address
//   m_wr_data       master write data
//   m_mask          master byte write mask
//   m_rd_data       read data, valid the cycle after a read request
//   s_en            per-slave enable, one-hot or zero
//   s_rdwr, s_addr, s_wr_data, s_mask
//                   broadcast request fields (s_addr is word aligned)
//   s_rd_data       packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   err_clr         clear the error status
//   err_flag        sticky unmapped-access flag
//   err_addr        address of the first unmapped access since the last clear
//   err_count       saturating unmapped-access count
module sysbus_decoder #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_HI   = 31,
  parameter int SEL_LO   = 28,
  parameter logic [N_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_REGION = {4'h3, 4'hA, 4'h9, 4'h0},
  parameter logic [N_SLAVES-1:0] REG_RD = 4'b0010,
  parameter int DEFAULT_SLAVE = 0,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_en,
  input  logic                         m_rdwr,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wr_data,
  input  logic [DATA_W/8-1:0]          m_mask,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic [N_SLAVES-1:0]          s_en,
  output logic                         s_rdwr,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wr_data,
  output logic [DATA_W/8-1:0]          s_mask,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rd_data,
  input  logic                         err_clr,
  output logic                         err_flag,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [7:0]                   err_count
);

  localparam int RW    = SEL_HI - SEL_LO + 1;
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  // Parameter sanity checks, reported while the design is elaborated.
  if (N_SLAVES < 1 || N_SLAVES > 8) begin : g_bad_n
    $error("sysbus_decoder: N_SLAVES must be in 1..8");
  end
  if (DEFAULT_SLAVE < 0 || DEFAULT_SLAVE > N_SLAVES) begin : g_bad_default
    $error("sysbus_decoder: DEFAULT_SLAVE must be in 0..N_SLAVES");
  end
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dup_outer
    for (genvar gj = gi + 1; gj < N_SLAVES; gj++) begin : g_dup_inner
      if (SLAVE_REGION[gi*RW +: RW] == SLAVE_REGION[gj*RW +: RW]) begin : g_dup
        $error("sysbus_decoder: duplicated SLAVE_REGION entry");
      end
    end
  end

  logic [IDX_W-1:0]           sel_idx;
  logic                       unmapped;
  logic                       rd_req;

  logic [IDX_W-1:0]           rd_sel_q, rd_sel_d;
  logic                       rd_err_q, rd_err_d;
  logic [N_SLAVES*DATA_W-1:0] cap_q, cap_d;

  logic                       err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]          err_addr_q, err_addr_d;
  logic [7:0]                 err_count_q, err_count_d;

  // Request fields go to every slave unconditionally; only s_en qualifies them.
  assign s_rdwr    = m_rdwr;
  assign s_addr    = {m_addr[ADDR_W-1:2], 2'b00};
  assign s_wr_data = m_wr_data;
  assign s_mask    = m_mask;

  assign rd_req = m_en & ~m_rdwr;

  // Region decode. Scanning from the top index down lets the lowest matching
  // slave overwrite any higher one, so the lowest index wins on overlap.
  // Without a hit, the access goes to the default slave, or is flagged
  // unmapped when no default slave exists.
  always_comb begin
    logic hit;
    hit      = 1'b0;
    sel_idx  = '0;
    unmapped = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (m_addr[SEL_HI:SEL_LO] == SLAVE_REGION[i*RW +: RW]) begin
        hit     = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    if (!hit) begin
      if (DEFAULT_SLAVE == N_SLAVES) begin
        unmapped = 1'b1;
      end else begin
        sel_idx = IDX_W'(DEFAULT_SLAVE);
      end
    end
    s_en = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      s_en[k] = m_en & ~unmapped & (sel_idx == IDX_W'(k));
    end
  end

  // Read pipeline next state. The selected slave and the unmapped status are
  // remembered on each read request; slaves that return combinational data
  // have it captured here so every slave presents the same one-cycle latency.
  always_comb begin
    rd_sel_d = rd_sel_q;
    rd_err_d = rd_err_q;
    cap_d    = cap_q;
    if (rd_req) begin
      rd_sel_d = sel_idx;
      rd_err_d = unmapped;
      for (int i = 0; i < N_SLAVES; i++) begin
        if (REG_RD[i]) begin
          cap_d[i*DATA_W +: DATA_W] = s_rd_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read return mux: unmapped reads get the fixed pattern, captured slaves
  // return the capture register, the rest pass their own registered data.
  always_comb begin
    m_rd_data = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (rd_sel_q == IDX_W'(i)) begin
        if (REG_RD[i]) begin
          m_rd_data = cap_q[i*DATA_W +: DATA_W];
        end else begin
          m_rd_data = s_rd_data[i*DATA_W +: DATA_W];
        end
      end
    end
    if (rd_err_q) begin
      m_rd_data = DEFAULT_RDATA;
    end
  end

  // Error status next state. A clear and a new error in the same cycle
  // behave as if the clear came first, so the new error is recorded fresh.
  always_comb begin
    err_flag_d  = err_flag_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      err_flag_d  = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end
    if (m_en && unmapped) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || err_clr) begin
        err_addr_d = m_addr;
      end
      if (err_clr) begin
        err_count_d = 8'd1;
      end else if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // All state registers share the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel_q    <= '0;
      rd_err_q    <= 1'b0;
      cap_q       <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_sel_q    <= rd_sel_d;
      rd_err_q    <= rd_err_d;
      cap_q       <= cap_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sysbus_decoder.sv
// Testbench for sysbus_decoder. Two instances share the same master and
// slave stimulus: u_def keeps the default parameters (unmatched addresses go
// to slave 0), u_err uses DEFAULT_SLAVE=4 so unmatched accesses are errors.
// Expected read data is queued when a read is driven and compared when the
// DUT returns it one cycle later.
module tb_sysbus_decoder;

  typedef enum {PH_RESET, PH_DECODE, PH_B2B, PH_UNMAPPED, PH_SATURATE, PH_RST_MID} phase_e;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_en, m_rdwr, err_clr;
  logic [31:0]  m_addr, m_wr_data;
  logic [3:0]   m_mask;
  logic [127:0] s_rd_data;

  logic [31:0]  d_rd_data, e_rd_data;
  logic [3:0]   d_s_en, e_s_en;
  logic         d_s_rdwr, e_s_rdwr;
  logic [31:0]  d_s_addr, e_s_addr, d_s_wr_data, e_s_wr_data;
  logic [3:0]   d_s_mask, e_s_mask;
  logic         d_err_flag, e_err_flag;
  logic [31:0]  d_err_addr, e_err_addr;
  logic [7:0]   d_err_count, e_err_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_def_q[$];
  logic [31:0] exp_err_q[$];
  bit          prev_read;
  logic [31:0] prev_addr;
  phase_e      phase;

  always #5 clk = ~clk;

  sysbus_decoder u_def (
    .clk(clk), .rst(rst), .m_en(m_en), .m_rdwr(m_rdwr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_mask(m_mask), .m_rd_data(d_rd_data),
    .s_en(d_s_en), .s_rdwr(d_s_rdwr), .s_addr(d_s_addr), .s_wr_data(d_s_wr_data),
    .s_mask(d_s_mask), .s_rd_data(s_rd_data), .err_clr(err_clr),
    .err_flag(d_err_flag), .err_addr(d_err_addr), .err_count(d_err_count)
  );

  sysbus_decoder #(.DEFAULT_SLAVE(4)) u_err (
    .clk(clk), .rst(rst), .m_en(m_en), .m_rdwr(m_rdwr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_mask(m_mask), .m_rd_data(e_rd_data),
    .s_en(e_s_en), .s_rdwr(e_s_rdwr), .s_addr(e_s_addr), .s_wr_data(e_s_wr_data),
    .s_mask(e_s_mask), .s_rd_data(s_rd_data), .err_clr(err_clr),
    .err_flag(e_err_flag), .err_addr(e_err_addr), .err_count(e_err_count)
  );

  // Reference decode from the region map: slave0=0x0, slave1=0x9,
  // slave2=0xA, slave3=0x3. Index 4 means unmapped.
  function automatic int modelSel(input logic [31:0] a, input bit dflt_err);
    case (a[31:28])
      4'h0:    return 0;
      4'h9:    return 1;
      4'hA:    return 2;
      4'h3:    return 3;
      default: return dflt_err ? 4 : 0;
    endcase
  endfunction

  // Data a slave returns for a given address; distinct per slave.
  function automatic logic [31:0] slaveData(input int i, input logic [31:0] a);
    return a ^ {4'(i + 1), 28'h1234567};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s (%s): got %h expected %h", tag, phase.name(), obs, exp);
    end
  endtask

  // One bus cycle. Slave 1 (captured by the decoder) drives its data only in
  // the request cycle; the other slaves drive data for the previous read in
  // the following cycle, and junk otherwise.
  task automatic applyStimulus(input bit en, input bit rdwr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit clr);
    int sd, se;
    logic [31:0] ed, ee;
    m_en      = en;
    m_rdwr    = rdwr;
    m_addr    = addr;
    m_wr_data = wdata;
    m_mask    = wdata[3:0];
    err_clr   = clr;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) s_rd_data[i*32 +: 32] = slaveData(1, addr);
      else if (prev_read) s_rd_data[i*32 +: 32] = slaveData(i, prev_addr);
      else s_rd_data[i*32 +: 32] = 32'h0BAD_0000 | i;
    end
    #4;
    sd = modelSel(addr, 1'b0);
    se = modelSel(addr, 1'b1);
    checkOutput("s_en_def", {28'd0, d_s_en}, en ? (32'd1 << sd) : 32'd0);
    checkOutput("s_en_err", {28'd0, e_s_en}, (en && se < 4) ? (32'd1 << se) : 32'd0);
    checkOutput("s_addr", d_s_addr, {addr[31:2], 2'b00});
    checkOutput("s_bcast", {d_s_wr_data[30:0], d_s_rdwr}, {wdata[30:0], rdwr});
    checkOutput("s_mask", {28'd0, e_s_mask}, {28'd0, wdata[3:0]});
    if (prev_read) begin
      checkOutput("rd_def", d_rd_data, exp_def_q.pop_front());
      checkOutput("rd_err", e_rd_data, exp_err_q.pop_front());
    end
    if (en && !rdwr) begin
      ed = slaveData(sd, addr);
      ee = (se == 4) ? 32'hDEAD_BEEF : slaveData(se, addr);
      exp_def_q.push_back(ed);
      exp_err_q.push_back(ee);
    end
    prev_read = en && !rdwr;
    prev_addr = addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    phase     = PH_RESET;
    rst       = 1'b1;
    m_en      = 1'b0;
    m_rdwr    = 1'b0;
    m_addr    = '0;
    m_wr_data = '0;
    m_mask    = '0;
    err_clr   = 1'b0;
    s_rd_data = '0;
    prev_read = 1'b0;
    prev_addr = '0;
    #12;
    checkOutput("rst_flag", {31'd0, e_err_flag}, 32'd0);
    checkOutput("rst_addr", e_err_addr, 32'd0);
    checkOutput("rst_count", {24'd0, e_err_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write and registered-path read to slave 1, plus word alignment.
    phase = PH_DECODE;
    $display("[TB] phase %s", phase.name());
    applyStimulus(1, 1, 32'h9000_0008, 32'hCAFE_F00D, 0);
    applyStimulus(1, 0, 32'h9000_0004, 32'h0, 0);
    applyStimulus(1, 1, 32'h3000_000B, 32'h0000_0005, 0);

    // Back-to-back reads across combinational and registered slaves.
    phase = PH_B2B;
    $display("[TB] phase %s", phase.name());
    applyStimulus(1, 0, 32'h0000_0010, 32'h0, 0);
    applyStimulus(1, 0, 32'hA000_0000, 32'h0, 0);
    applyStimulus(1, 0, 32'h9000_0020, 32'h0, 0);
    applyStimulus(1, 0, 32'h9000_0024, 32'h0, 0);
    applyStimulus(1, 0, 32'h3000_0100, 32'h0, 0);
    applyStimulus(0, 0, 32'h0000_0000, 32'h0, 0);
    checkOutput("err_none", {31'd0, e_err_flag}, 32'd0);

    // Unmapped read: default slave on u_def, error on u_err.
    phase = PH_UNMAPPED;
    $display("[TB] phase %s", phase.name());
    applyStimulus(1, 0, 32'h5000_0000, 32'h0, 0);
    checkOutput("unm_flag", {31'd0, e_err_flag}, 32'd1);
    checkOutput("unm_addr", e_err_addr, 32'h5000_0000);
    checkOutput("unm_count", {24'd0, e_err_count}, 32'd1);
    checkOutput("def_flag", {31'd0, d_err_flag}, 32'd0);
    applyStimulus(1, 1, 32'h6000_0000, 32'h1, 0);
    checkOutput("unm_addr2", e_err_addr, 32'h5000_0000);
    checkOutput("unm_count2", {24'd0, e_err_count}, 32'd2);

    // Saturation, then clear colliding with a new error, then a plain clear.
    phase = PH_SATURATE;
    $display("[TB] phase %s", phase.name());
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1, k[0], 32'h5000_0000 + 32'(k << 2), 32'h0, 0);
    end
    checkOutput("sat_count", {24'd0, e_err_count}, 32'd255);
    checkOutput("sat_addr", e_err_addr, 32'h5000_0000);
    applyStimulus(1, 1, 32'h7000_0004, 32'h0, 1);
    checkOutput("clr_err_flag", {31'd0, e_err_flag}, 32'd1);
    checkOutput("clr_err_count", {24'd0, e_err_count}, 32'd1);
    checkOutput("clr_err_addr", e_err_addr, 32'h7000_0004);
    applyStimulus(0, 0, 32'h0, 32'h0, 1);
    checkOutput("clr_flag", {31'd0, e_err_flag}, 32'd0);
    checkOutput("clr_count", {24'd0, e_err_count}, 32'd0);
    checkOutput("clr_addr", e_err_addr, 32'd0);
    applyStimulus(1, 1, 32'hC000_0040, 32'h0, 0);
    checkOutput("pre_rst_count", {24'd0, e_err_count}, 32'd1);

    // Reset between a read request and its return.
    phase = PH_RST_MID;
    $display("[TB] phase %s", phase.name());
    applyStimulus(1, 0, 32'h9000_0004, 32'h0, 0);
    rst  = 1'b1;
    m_en = 1'b0;
    #1;
    checkOutput("arst_flag", {31'd0, e_err_flag}, 32'd0);
    checkOutput("arst_addr", e_err_addr, 32'd0);
    checkOutput("arst_count", {24'd0, e_err_count}, 32'd0);
    void'(exp_def_q.pop_front());
    void'(exp_err_q.pop_front());
    prev_read = 1'b0;
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 32'h9000_0008, 32'h0, 0);
    applyStimulus(1, 0, 32'hA000_0008, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysbus_decoder.md
Name: sysbus_decoder

Overview:
- Parametrised N-slave address decoder and read-data return mux for the RISC_V system bus.
- Successor to the fixed two-way memory/GEMM split in top: region-matched routing over any number of slaves, selectable per-slave read-data registering, an optional default slave, and error capture for unmapped accesses.
- Sits between the RISC_V system bus port and the memory, gemm configuration and future peripherals.

Parameters:
N_SLAVES, 4, number of slave ports (1..8)
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (multiple of 8)
SEL_HI, 31, MSB of region field in address
SEL_LO, 28, LSB of region field (field width RW = SEL_HI-SEL_LO+1)
SLAVE_REGION, {4'h3,4'hA,4'h9,4'h0}, packed N_SLAVES*RW region codes, slave i at bits [i*RW +: RW]
REG_RD, 4'b0010, bit i=1: decoder registers slave i's combinational read data; 0: slave returns registered data itself
DEFAULT_SLAVE, 0, slave receiving unmatched addresses; value N_SLAVES means unmatched accesses are errors
DEFAULT_RDATA, 32'hDEAD_BEEF, read data returned for unmapped reads

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
m_en  input  1  bus access request
m_rdwr  input  1  1=write, 0=read
m_addr  input  ADDR_W  byte address
m_wr_data  input  DATA_W  write data
m_mask  input  DATA_W/8  byte write mask
m_rd_data  output  DATA_W  read data, valid the cycle after a read request
s_en  output  N_SLAVES  per-slave enable, one-hot or zero
s_rdwr  output  1  broadcast of m_rdwr
s_addr  output  ADDR_W  word-aligned address {m_addr[ADDR_W-1:2],2'b00}
s_wr_data  output  DATA_W  broadcast write data
s_mask  output  DATA_W/8  broadcast mask
s_rd_data  input  N_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
err_clr  input  1  clear error status
err_flag  output  1  sticky unmapped-access flag
err_addr  output  ADDR_W  address of first unmapped access since last clear
err_count  output  8  saturating unmapped-access count

Behaviour:
- Clocking and reset: single clock, clk. rst is asynchronous, active-high. On reset: err_flag=0, err_addr=0, err_count=0, rd_sel=0, rd_err=0, all read capture registers=0.
- Decode (combinational, same cycle):
  - hit[i] = (m_addr[SEL_HI:SEL_LO] == SLAVE_REGION[i]).
  - If several slaves hit, the lowest index wins.
  - No hit: route to DEFAULT_SLAVE, or mark unmapped if DEFAULT_SLAVE==N_SLAVES.
  - s_en[k] = m_en & selected(k). Never more than one bit set.
  - s_rdwr, s_addr, s_wr_data and s_mask are driven continuously, regardless of m_en.
- Writes: reach the slave in the request cycle. No response. Unmapped writes are dropped (s_en=0).
- Read pipeline (latency exactly 1 cycle for every slave):
  - Request in cycle T (m_en=1, m_rdwr=0): at the posedge ending T, register rd_sel<=selected index and rd_err<=unmapped.
  - For each i with REG_RD[i]=1, capture cap[i]<=s_rd_data[i] at the same edge.
  - In cycle T+1, m_rd_data is selected in this order:
    - rd_err=1: DEFAULT_RDATA.
    - REG_RD[rd_sel]=1: cap[rd_sel].
    - Otherwise: s_rd_data[rd_sel] passed combinationally.
  - rd_sel, rd_err and cap update only on read requests. m_rd_data is specified only in the cycle after a read.
  - Back-to-back reads to different slaves each return correct data at T+1 with no bubble.
- Error tracking (on every unmapped access with m_en=1, read or write, at the posedge ending the request cycle):
  - err_flag<=1.
  - err_addr<=m_addr only if err_flag was 0 (first error is sticky).
  - err_count<=err_count+1, saturating at 255.
- err_clr: clears err_flag, err_addr and err_count at the next edge.
  - err_clr together with a new error: the error wins, giving flag=1, count=1, err_addr=the new address.
- Reset asserted mid-read: outputs return to reset values immediately. The pending read is lost, and m_rd_data in the following cycle is unspecified.
- Elaboration checks: flag at elaboration if N_SLAVES>8, if DEFAULT_SLAVE>N_SLAVES, or if any SLAVE_REGION entries are duplicated.

Test Plan:
1. Defaults. Write to 0x9000_0008 -> s_en=4'b0010 that cycle, s_addr=0x9000_0008. Read 0x9000_0004 where slave1 drives 0x1234_5678 in cycle T only -> m_rd_data=0x1234_5678 at T+1 (registered path).
2. Back-to-back reads 0x0000_0010 (slave0 returns 0xAAAA_0001) then 0xA000_0000 (slave2 returns 0xBBBB_0002) -> m_rd_data reads 0xAAAA_0001 then 0xBBBB_0002 on consecutive cycles.
3. Defaults. Read 0x5000_0000 (no region) -> s_en=4'b0001 and slave0 data returned; err_flag stays 0.
4. DEFAULT_SLAVE=4. Read 0x5000_0000 -> s_en=0, m_rd_data=0xDEAD_BEEF at T+1, err_flag=1, err_addr=0x5000_0000, err_count=1. Then write 0x6000_0000 -> err_addr unchanged, err_count=2.
5. DEFAULT_SLAVE=4. 300 unmapped accesses -> err_count=255. Then err_clr together with an unmapped access at 0x7000_0004 -> err_flag=1, err_count=1, err_addr=0x7000_0004.
6. Assert rst mid-read between T and T+1 -> err_*=0 asynchronously; the next read to slave1 returns correct data.
